inst_fetch_buffer: RTL



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/inst_fetch_buffer_if.sv | 27 ++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/inst_fetch_buffer.sv | 104 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

    localparam int INST_W      = 32;
    localparam int WORD_ADDR_W = 30;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fifo_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
interface inst_fetch_buffer_if;
    import fetch_pkg::*;

    logic                   mem_req;
    logic [WORD_ADDR_W-1:0] mem_addr;
    logic                   mem_gnt;
    logic                   mem_rvalid;
    logic [INST_W-1:0]      mem_rdata;
    logic                   inst_valid;
    logic [INST_W-1:0]      inst;
    logic [31:0]            inst_pc;
    logic                   inst_ready;
    logic                   redirect;
    logic [31:0]            redirect_pc;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, inst} with occupancy count and flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fifo_entry_t      push_data,
    input  logic             pop,
    input  logic             flush,
    output fifo_entry_t      head,
    output logic [CNT_W-1:0] count
);

    fifo_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues one outstanding word request, buffers responses.
// Optional same-cycle response bypass to decode when FETCH_BYPASS_EN is defined.
//
// state | meaning
// IDLE  | no request, waiting for FIFO credit
// REQ   | mem_req asserted, holding address until grant
// WAIT  | request granted, response will be enqueued
// DROP  | request granted before a redirect, response will be discarded
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic                 clock,
    input logic                 reset,
    inst_fetch_buffer_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CW    = CNT_W + 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_DROP = DROP;

    logic [1:0]       state, state_next;
    logic [31:0]      fetch_pc, req_pc;
    logic [CNT_W-1:0] fifo_count;
    logic [CW-1:0]    count_after;
    fifo_entry_t      head, push_data;
    logic             outstanding, credit, credit_after, fire, accept;
    logic             push, pop, fifo_empty, bypass_take;

    assign outstanding  = (state == S_WAIT) || (state == S_DROP);
    assign credit       = ({1'b0, fifo_count} + CW'(outstanding)) < CW'(DEPTH);
    assign fire         = bus.mem_req && bus.mem_gnt;
    assign accept       = (state == S_WAIT) && bus.mem_rvalid && !bus.redirect;
    assign fifo_empty   = (fifo_count == '0);
    assign push         = accept && !bypass_take;
    assign pop          = !fifo_empty && bus.inst_ready && !bus.redirect;
    assign count_after  = {1'b0, fifo_count} + CW'(push) - CW'(pop);
    assign credit_after = count_after < CW'(DEPTH);
    assign push_data    = '{pc: req_pc, inst: bus.mem_rdata};

    assign bus.mem_req  = (state == S_REQ) && credit;
    assign bus.mem_addr = fetch_pc[31:2];

`ifdef FETCH_BYPASS_EN
    assign bypass_take    = accept && fifo_empty && bus.inst_ready;
    assign bus.inst_valid = !fifo_empty || accept;
    assign bus.inst       = (fifo_empty && accept) ? bus.mem_rdata : head.inst;
    assign bus.inst_pc    = (fifo_empty && accept) ? req_pc : head.pc;
`else
    assign bypass_take    = 1'b0;
    assign bus.inst_valid = !fifo_empty;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (credit) state_next = S_REQ;
            S_REQ:   if (fire) state_next = S_WAIT;
            S_WAIT:  if (bus.mem_rvalid) state_next = credit_after ? S_REQ : S_IDLE;
            S_DROP:  if (bus.mem_rvalid) state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
        // A response landing in the redirect cycle retires the outstanding request,
        // so there is nothing left to drop.
        if (bus.redirect) begin
            if ((state == S_REQ && fire) ||
                (outstanding && !bus.mem_rvalid)) state_next = S_DROP;
            else                                  state_next = S_REQ;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state <= state_next;
            if (fire) req_pc <= fetch_pc;
            if (bus.redirect)  fetch_pc <= bus.redirect_pc & ~32'd3;
            else if (fire)     fetch_pc <= fetch_pc + 32'd4;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.redirect),
        .head      (head),
        .count     (fifo_count)
    );

endmodule
